dbg_halt_ctrl: RTL
==================

Name: dbg_halt_ctrl

Overview:
Debug run-control sequencer between the JTAG debug module and the pipeline stall/redirect logic. It turns JTAG halt, resume, single-step and reset requests into a clean, drained pipeline stall. It holds the core halted until released and reports status back to JTAG. Its stall output feeds the pipeline controller's halt input.

Parameters:
DRAIN_MAX, 16, max cycles spent draining before a forced halt (min 2)
RESET_CYCLES, 4, cycles the debug reset is held (min 1)
CNT_W, 5, width of the shared drain/reset counter; must hold max(DRAIN_MAX, RESET_CYCLES)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
jtag_halt_req  in  1  level; request halt
jtag_resume_req  in  1  one-cycle pulse; leave halt
jtag_step_req  in  1  one-cycle pulse; execute one instruction then re-halt
jtag_reset_req  in  1  one-cycle pulse; debug reset
ifu_ctrl_valid  in  1  instruction retired this cycle
biu_ctrl_stall  in  1  bus transaction outstanding
int_ctrl_flush_req  in  1  interrupt flush in progress
dbg_ctrl_halt  out  1  stall request to pipeline controller
dbg_ctrl_reset  out  1  PC reset request, high during RESET
dbg_halted  out  1  core halted (state HALTED)
dbg_halt_ack  out  1  one-cycle pulse when a halt completes
dbg_step_done  out  1  one-cycle pulse when a step completes
dbg_drain_timeout  out  1  sticky; last drain was forced
dbg_state  out  3  current state encoding for JTAG status

Behaviour:
- States and encodings: RUN=0, DRAIN=1, HALTED=2, STEP=3, RESET=4.
- Registered FSM plus one counter cnt[CNT_W-1:0] and a step_flag register. All outputs are registered.
- Reset values: state RUN, cnt 0, step_flag 0. All outputs 0 except dbg_state=0.
- dbg_ctrl_halt=1 in DRAIN, HALTED and RESET; 0 in RUN and STEP. dbg_halted=1 only in HALTED. dbg_ctrl_reset=1 only in RESET.
- Priority, highest first: jtag_reset_req, then resume, then step, then halt.
- jtag_reset_req in any state: next state RESET, cnt cleared, step_flag cleared. A pulse arriving while already in RESET restarts the count.
- RESET: cnt increments each cycle. When cnt==RESET_CYCLES-1, go to DRAIN if jtag_halt_req=1, else RUN. dbg_ctrl_reset therefore stays high for exactly RESET_CYCLES cycles.
- RUN: if jtag_halt_req=1, go to DRAIN with cnt=0 and step_flag=0.
- DRAIN: each cycle, if biu_ctrl_stall=0 and int_ctrl_flush_req=0, go to HALTED. Otherwise increment cnt; when cnt==DRAIN_MAX-1 and not yet clean, go to HALTED and set dbg_drain_timeout.
  - On a clean drain, dbg_drain_timeout is cleared.
  - On entering HALTED, pulse dbg_step_done if step_flag=1, else pulse dbg_halt_ack. The pulse is asserted in the first HALTED cycle. step_flag is cleared on the same edge.
  - Minimum DRAIN residency is 1 cycle: halt_ack asserts no earlier than 2 cycles after halt_req is sampled.
- HALTED: jtag_resume_req goes to RUN. Resume is ignored while jtag_halt_req is still 1, so the core stays halted. Otherwise, jtag_step_req goes to STEP. Resume and step asserted together: resume wins.
- STEP: stall released. On the first cycle with ifu_ctrl_valid=1, go to DRAIN with step_flag=1 and cnt=0. Exactly one retirement is allowed.
  - If ifu_ctrl_valid is not seen within DRAIN_MAX cycles (cnt reuse), go to DRAIN anyway with step_flag=1.
- jtag_halt_req deasserting during DRAIN does not abort the drain; the block completes into HALTED.
- resume or step pulses in RUN, DRAIN, STEP or RESET are ignored.
- rst_n low mid-operation returns all state to reset values asynchronously. No pulse outputs are generated on reset release.

Test Plan:
- Basic halt: after reset, halt_req=1 with biu_ctrl_stall=0 -> DRAIN for 1 cycle, then HALTED. halt_ack high for exactly 1 cycle; dbg_ctrl_halt=1 from cycle 1; dbg_state 0->1->2.
- Drain wait: halt_req=1 with biu_ctrl_stall=1 for 5 cycles, then 0 -> HALTED on cycle 6 after halt_req; timeout=0. Repeat with stall held high -> HALTED after 16 DRAIN cycles, dbg_drain_timeout=1, then a clean halt clears it.
- Resume gating: HALTED, halt_req=1, resume pulse -> stays HALTED. Drop halt_req, resume pulse -> RUN next cycle; dbg_halted=0, dbg_ctrl_halt=0.
- Single step: HALTED, step pulse -> STEP, stall=0. ifu_ctrl_valid pulse after 3 cycles -> DRAIN -> HALTED. dbg_step_done pulses once, no halt_ack. Also: step with no retire -> forced back to HALTED after 16 cycles.
- Reset priority: in STEP, assert reset_req and step together -> RESET. dbg_ctrl_reset high 4 cycles, then RUN (halt_req=0) or DRAIN (halt_req=1). Reset pulse during RESET restarts the 4-cycle count.
- Async reset: rst_n low during DRAIN -> all outputs 0 immediately, state RUN. No halt_ack after release.

Source files
------------

// File: rtl/dbg_halt_ctrl.sv
// Debug run-control sequencer: converts JTAG halt/resume/step/reset requests
// into a drained pipeline stall, holds the core halted and reports status.
module dbg_halt_ctrl #(
    parameter int DRAIN_MAX    = 16,
    parameter int RESET_CYCLES = 4,
    parameter int CNT_W        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       jtag_halt_req,
    input  logic       jtag_resume_req,
    input  logic       jtag_step_req,
    input  logic       jtag_reset_req,
    input  logic       ifu_ctrl_valid,
    input  logic       biu_ctrl_stall,
    input  logic       int_ctrl_flush_req,
    output logic       dbg_ctrl_halt,
    output logic       dbg_ctrl_reset,
    output logic       dbg_halted,
    output logic       dbg_halt_ack,
    output logic       dbg_step_done,
    output logic       dbg_drain_timeout,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_HALTED = 3'd2,
        ST_STEP   = 3'd3,
        ST_RESET  = 3'd4
    } state_t;

    // Terminal counts for the shared drain/step/reset counter
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             step_flag_reg, step_flag_next;
    logic             timeout_reg, timeout_next;
    logic             halt_ack_next, step_done_next;
    logic             drain_clean;

    // A drain completes cleanly once neither the bus nor an interrupt flush is busy
    assign drain_clean = !biu_ctrl_stall && !int_ctrl_flush_req;

    // Next-state, counter and pulse logic; reset request overrides everything
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        step_flag_next = step_flag_reg;
        timeout_next   = timeout_reg;
        halt_ack_next  = 1'b0;
        step_done_next = 1'b0;

        if (jtag_reset_req) begin
            state_next     = ST_RESET;
            cnt_next       = '0;
            step_flag_next = 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (jtag_halt_req) begin
                        state_next     = ST_DRAIN;
                        cnt_next       = '0;
                        step_flag_next = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_clean) begin
                        state_next   = ST_HALTED;
                        timeout_next = 1'b0;
                    end else if (cnt_reg == DRAIN_LAST) begin
                        state_next   = ST_HALTED;
                        timeout_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                ST_HALTED: begin
                    // Resume only counts once the halt level has been dropped
                    if (jtag_resume_req && !jtag_halt_req) begin
                        state_next = ST_RUN;
                    end else if (jtag_step_req) begin
                        state_next = ST_STEP;
                        cnt_next   = '0;
                    end
                end
                ST_STEP: begin
                    // One retirement, or give up after DRAIN_MAX cycles
                    if (ifu_ctrl_valid || (cnt_reg == DRAIN_LAST)) begin
                        state_next     = ST_DRAIN;
                        cnt_next       = '0;
                        step_flag_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                ST_RESET: begin
                    if (cnt_reg == RESET_LAST) begin
                        state_next = jtag_halt_req ? ST_DRAIN : ST_RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_next     = ST_RUN;
                    cnt_next       = '0;
                    step_flag_next = 1'b0;
                end
            endcase

            // Completion pulse on entry to HALTED tells JTAG which request finished
            if ((state_next == ST_HALTED) && (state_reg != ST_HALTED)) begin
                halt_ack_next  = !step_flag_reg;
                step_done_next = step_flag_reg;
                step_flag_next = 1'b0;
            end
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_RUN;
            cnt_reg           <= '0;
            step_flag_reg     <= 1'b0;
            timeout_reg       <= 1'b0;
            dbg_ctrl_halt     <= 1'b0;
            dbg_ctrl_reset    <= 1'b0;
            dbg_halted        <= 1'b0;
            dbg_halt_ack      <= 1'b0;
            dbg_step_done     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            step_flag_reg     <= step_flag_next;
            timeout_reg       <= timeout_next;
            dbg_ctrl_halt     <= (state_next == ST_DRAIN) || (state_next == ST_HALTED) ||
                                 (state_next == ST_RESET);
            dbg_ctrl_reset    <= (state_next == ST_RESET);
            dbg_halted        <= (state_next == ST_HALTED);
            dbg_halt_ack      <= halt_ack_next;
            dbg_step_done     <= step_done_next;
        end
    end

    assign dbg_drain_timeout = timeout_reg;
    assign dbg_state         = state_reg;

endmodule
